// File: rtl/z80_bus_tracer.sv
// Passive tv80s bus monitor: classifies completed bus cycles into {type,addr,data} records.
// Latency: record on rec_* from the edge that samples the end of the cycle (registered head).
// Backpressure: rec_valid/rec_ready pop; full FIFO drops new records and counts them saturating.
module z80_bus_tracer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   m1_n,
    input  logic                   mreq_n,
    input  logic                   iorq_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic                   rfsh_n,
    input  logic [15:0]            A,
    input  logic [7:0]             di,
    input  logic [7:0]             dout,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [2:0]             rec_type,
    output logic [15:0]            rec_addr,
    output logic [7:0]             rec_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       drops
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = 27;

    localparam logic [2:0] T_FETCH  = 3'd0;
    localparam logic [2:0] T_MEMRD  = 3'd1;
    localparam logic [2:0] T_MEMWR  = 3'd2;
    localparam logic [2:0] T_IORD   = 3'd3;
    localparam logic [2:0] T_IOWR   = 3'd4;
    localparam logic [2:0] T_INTACK = 3'd5;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]    state;
    logic [2:0]    cur_type;
    logic [15:0]   cur_addr;
    logic [7:0]    cur_data;
    logic          cls_vld;
    logic [2:0]    cls;
    logic [7:0]    cls_dat;
    logic          same;
    logic          start;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          full;
    logic [RW-1:0] push_rec;
    logic [RW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_nxt;

    // Int-ack is checked first: it is the only class with M1 and IORQ both low.
    always_comb begin
        cls_vld = 1'b0;
        cls     = T_FETCH;
        if (rfsh_n) begin
            if (!m1_n && !iorq_n) begin
                cls_vld = 1'b1; cls = T_INTACK;
            end else if (!m1_n && !mreq_n && !rd_n) begin
                cls_vld = 1'b1; cls = T_FETCH;
            end else if (m1_n && !mreq_n && !rd_n) begin
                cls_vld = 1'b1; cls = T_MEMRD;
            end else if (!mreq_n && !wr_n) begin
                cls_vld = 1'b1; cls = T_MEMWR;
            end else if (!iorq_n && !rd_n) begin
                cls_vld = 1'b1; cls = T_IORD;
            end else if (!iorq_n && !wr_n) begin
                cls_vld = 1'b1; cls = T_IOWR;
            end
        end
    end

    assign cls_dat  = (cls == T_MEMWR || cls == T_IOWR) ? dout : di;
    assign same     = (state == S_ACTIVE) && cls_vld && (cls == cur_type);
    // en only gates the start of a capture; an ongoing cycle runs to completion.
    assign start    = en && cls_vld;
    assign push_req = (state == S_ACTIVE) && !same;
    assign push_rec = {cur_type, cur_addr, cur_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cur_type <= '0;
            cur_addr <= '0;
            cur_data <= '0;
        end else begin
            if (same || start) begin
                cur_type <= cls;
                cur_addr <= A;
                cur_data <= cls_dat;
                state    <= S_ACTIVE;
            end else begin
                state    <= S_IDLE;
            end
        end
    end

    assign rec_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = rec_valid && rec_ready;
    assign do_push   = push_req && (!full || do_pop);
    assign rd_nxt    = rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    // Head register mirrors mem[rd_ptr] so rec_* come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drops    <= '0;
            rec_type <= '0;
            rec_addr <= '0;
            rec_data <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_nxt;
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !do_push && drops != '1) begin
                drops <= drops + CNT_W'(1);
            end
            if (do_pop) begin
                if (count > CW'(1)) begin
                    {rec_type, rec_addr, rec_data} <= mem[rd_nxt];
                end else if (do_push) begin
                    {rec_type, rec_addr, rec_data} <= push_rec;
                end
            end else if (do_push && count == '0) begin
                {rec_type, rec_addr, rec_data} <= push_rec;
            end
        end
    end
endmodule

// File: tb/tb_z80_bus_tracer.sv
// Bench for z80_bus_tracer: vector table of bus cycles plus hand sequences for full/reset cases.
module tb_z80_bus_tracer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [15:0] A;
    logic [7:0]  di, dout;
    logic        rec_valid, rec_ready;
    logic [2:0]  rec_type;
    logic [15:0] rec_addr;
    logic [7:0]  rec_data;
    logic [4:0]  count;
    logic [7:0]  drops;

    always #5 clk = ~clk;

    z80_bus_tracer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
        .A(A), .di(di), .dout(dout),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_type(rec_type), .rec_addr(rec_addr), .rec_data(rec_data),
        .count(count), .drops(drops)
    );

    typedef struct {
        logic [2:0]  typ;
        logic [15:0] addr;
        logic [7:0]  data;
        int          len;
        int          gap;
        bit          en;
        bit          rfsh;
    } vec_t;

    vec_t        vt[10];
    logic [26:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted head record is compared against the oldest expected one.
    always @(negedge clk) begin
        if (!reset && rec_valid && rec_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rec: got %0h expected none", {rec_type, rec_addr, rec_data});
            end else begin
                check("rec", {rec_type, rec_addr, rec_data}, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1; en = 1'b1;
    endtask

    // Drive one bus class; the unused data bus carries the inverse as a decoy.
    task automatic drive(input logic [2:0] typ, input logic [15:0] a, input logic [7:0] d);
        idle_bus();
        A = a; di = ~d; dout = ~d;
        case (typ)
            3'd0:    begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; di = d; end
            3'd1:    begin mreq_n = 1'b0; rd_n = 1'b0; di = d; end
            3'd2:    begin mreq_n = 1'b0; wr_n = 1'b0; dout = d; end
            3'd3:    begin iorq_n = 1'b0; rd_n = 1'b0; di = d; end
            3'd4:    begin iorq_n = 1'b0; wr_n = 1'b0; dout = d; end
            default: begin m1_n = 1'b0; iorq_n = 1'b0; di = d; end
        endcase
    endtask

    task automatic run(input vec_t v);
        for (int k = 0; k < v.len; k++) begin
            drive(v.typ, v.addr, v.data);
            en = v.en;
            rfsh_n = v.rfsh;
            step();
        end
        if (v.en && v.rfsh) sb.push_back({v.typ, v.addr, v.data});
        for (int k = 0; k < v.gap; k++) begin
            idle_bus();
            step();
        end
    endtask

    task automatic wait_empty(input int budget);
        for (int k = 0; k < budget && count != 0; k++) step();
        check("drain_count", 32'(count), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3'd2, 16'h8000, 8'h5a, 2, 1, 1'b1, 1'b1};
        vt[1] = '{3'd3, 16'h00fe, 8'h3c, 1, 0, 1'b1, 1'b1};
        vt[2] = '{3'd4, 16'h00fe, 8'h77, 1, 1, 1'b1, 1'b1};
        vt[3] = '{3'd0, 16'h0100, 8'h3e, 2, 0, 1'b1, 1'b1};
        vt[4] = '{3'd1, 16'h0101, 8'h42, 2, 1, 1'b1, 1'b1};
        vt[5] = '{3'd5, 16'hffff, 8'hff, 2, 1, 1'b1, 1'b1};
        vt[6] = '{3'd1, 16'h2000, 8'h99, 2, 1, 1'b0, 1'b1};
        vt[7] = '{3'd1, 16'h0038, 8'hc3, 1, 1, 1'b1, 1'b0};
        vt[8] = '{3'd2, 16'h4000, 8'ha5, 3, 0, 1'b1, 1'b1};
        vt[9] = '{3'd1, 16'h4001, 8'h5b, 1, 2, 1'b1, 1'b1};

        reset = 1'b1; rec_ready = 1'b0;
        idle_bus(); A = '0; di = '0; dout = '0;
        #1;
        check("rst_valid", 32'(rec_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_drops", 32'(drops), 0);
        check("rst_rec", {rec_type, rec_addr, rec_data}, 0);
        step(); step();
        reset = 1'b0;

        // Opcode fetch of DEC DE at PC 0 followed by its refresh cycle.
        drive(3'd0, 16'h0000, 8'h1b); step(); step();
        sb.push_back({3'd0, 16'h0000, 8'h1b});
        idle_bus(); rfsh_n = 1'b0; mreq_n = 1'b0; A = 16'h0000;
        step();
        check("push_edge_count", 32'(count), 1);
        check("push_edge_valid", 32'(rec_valid), 1);
        step();
        idle_bus(); step();
        check("after_rfsh_count", 32'(count), 1);
        check("head_fetch", {rec_type, rec_addr, rec_data}, {3'd0, 16'h0000, 8'h1b});
        drive(3'd0, 16'h0001, 8'h13); step();
        sb.push_back({3'd0, 16'h0001, 8'h13});
        idle_bus(); step();
        check("second_fetch_count", 32'(count), 2);
        rec_ready = 1'b1;
        wait_empty(10);

        for (int i = 0; i < 10; i++) run(vt[i]);
        wait_empty(20);
        check("table_sb_empty", 32'(sb.size()), 0);

        // en falls mid-cycle; record keeps the last active edge's address/data.
        drive(3'd1, 16'h1000, 8'h11); step();
        drive(3'd1, 16'h1001, 8'h22); en = 1'b0; step(); step();
        sb.push_back({3'd1, 16'h1001, 8'h22});
        idle_bus(); step();
        wait_empty(10);

        // Overfill: DEPTH+3 reads with the consumer stalled.
        rec_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            drive(3'd1, 16'(16'h3000 + i), i[7:0]); step();
            if (i < DEPTH) sb.push_back({3'd1, 16'(16'h3000 + i), i[7:0]});
            idle_bus(); step();
        end
        check("full_count", 32'(count), DEPTH);
        check("full_drops", 32'(drops), 3);
        check("full_head", {rec_type, rec_addr, rec_data}, {3'd1, 16'h3000, 8'h00});

        // Push and pop on the same edge while full.
        drive(3'd2, 16'h5555, 8'h66); step();
        idle_bus(); rec_ready = 1'b1; step();
        rec_ready = 1'b0;
        sb.push_back({3'd2, 16'h5555, 8'h66});
        check("pushpop_count", 32'(count), DEPTH);
        check("pushpop_drops", 32'(drops), 3);
        rec_ready = 1'b1;
        wait_empty(2 * DEPTH + 10);
        check("full_sb_empty", 32'(sb.size()), 0);

        // Reset in the middle of a write with a record already queued.
        rec_ready = 1'b0;
        drive(3'd1, 16'h0777, 8'h01); step();
        idle_bus(); step();
        drive(3'd2, 16'h9000, 8'hee); step(); step();
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(rec_valid), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_rec", {rec_type, rec_addr, rec_data}, 0);
        sb.delete();
        idle_bus(); step();
        reset = 1'b0;
        step(); step(); step();
        check("post_rst_count", 32'(count), 0);
        check("post_rst_valid", 32'(rec_valid), 0);
        rec_ready = 1'b1;
        drive(3'd4, 16'h0042, 8'h24); step();
        sb.push_back({3'd4, 16'h0042, 8'h24});
        idle_bus(); step();
        wait_empty(10);
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
